// File: rtl/parallel_mac_pkg.sv
// rtl/parallel_mac_pkg.sv - shared states, default sizes and beat-count helper for the dot-product engine
package parallel_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_PARALLEL = 1;
  localparam int DEF_N_ELEM   = 25;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ACC_W    = 16;

  function automatic int beat_count(input int n_elem, input int parallel);
    return (n_elem + parallel - 1) / parallel;
  endfunction

endpackage

// File: rtl/mac_lane_sum.sv
// rtl/mac_lane_sum.sv - combinational sum of lane products for one beat, padding lanes masked
module mac_lane_sum #(
  parameter int PARALLEL = 1,
  parameter int N_ELEM   = 25,
  parameter int DATA_W   = 8,
  parameter int BEAT_W   = 5,
  parameter int SUM_W    = 2 * DATA_W + $clog2(PARALLEL)
) (
  input  logic [PARALLEL*DATA_W-1:0] din_a,
  input  logic [PARALLEL*DATA_W-1:0] din_b,
  input  logic [BEAT_W-1:0]          beat,
  output logic [SUM_W-1:0]           sum
);

  logic [SUM_W-1:0]    lane_total;
  logic [2*DATA_W-1:0] op_a;
  logic [2*DATA_W-1:0] op_b;
  logic [2*DATA_W-1:0] prod;
  int                  idx;

  always_comb begin
    lane_total = '0;
    op_a       = '0;
    op_b       = '0;
    prod       = '0;
    idx        = 0;
    for (int j = 0; j < PARALLEL; j++) begin
      idx  = int'(beat) * PARALLEL + j;
      op_a = {{DATA_W{1'b0}}, din_a[j*DATA_W +: DATA_W]};
      op_b = {{DATA_W{1'b0}}, din_b[j*DATA_W +: DATA_W]};
      prod = op_a * op_b;
      // Lanes past the last element carry source padding and must not contribute.
      if (idx < N_ELEM) begin
        lane_total = lane_total + SUM_W'(prod);
      end
    end
  end

  assign sum = lane_total;

endmodule

// File: rtl/parallel_mac.sv
// rtl/parallel_mac.sv - fixed-length dot-product engine: FSM, beat counter and wrapping accumulator
module parallel_mac
  import parallel_mac_pkg::*;
#(
  parameter int PARALLEL = DEF_PARALLEL,
  parameter int N_ELEM   = DEF_N_ELEM,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       start,
  input  logic [PARALLEL*DATA_W-1:0] din_a,
  input  logic [PARALLEL*DATA_W-1:0] din_b,
  output logic [ACC_W-1:0]           dout,
  output logic                       done
);

  localparam int BEATS  = beat_count(N_ELEM, PARALLEL);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SUM_W  = 2 * DATA_W + $clog2(PARALLEL);

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [SUM_W-1:0]  lane_sum;

  mac_lane_sum #(
    .PARALLEL (PARALLEL),
    .N_ELEM   (N_ELEM),
    .DATA_W   (DATA_W),
    .BEAT_W   (BEAT_W),
    .SUM_W    (SUM_W)
  ) u_lane_sum (
    .din_a (din_a),
    .din_b (din_b),
    .beat  (beat_q),
    .sum   (lane_sum)
  );

  // beat_q is zero whenever IDLE, so the first beat is consumed on the start edge.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    acc_d   = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d = ACC_W'(lane_sum);
          if (BEATS == 1) begin
            state_d = ST_DONE;
            beat_d  = '0;
          end else begin
            state_d = ST_RUN;
            beat_d  = BEAT_W'(1);
          end
        end
      end
      ST_RUN: begin
        acc_d = acc_q + ACC_W'(lane_sum);
        if (beat_q == BEAT_W'(BEATS - 1)) begin
          state_d = ST_DONE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      ST_DONE: begin
        if (!start) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      acc_q   <= acc_d;
    end
  end

  assign dout = acc_q;
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_parallel_mac.sv
// tb/tb_parallel_mac.sv - directed self-checking bench for parallel_mac at one and four lanes
module tb_parallel_mac;

  logic        clk;
  logic        rst_b;
  logic        start1;
  logic        start4;
  logic [7:0]  din_a1, din_b1;
  logic [31:0] din_a4, din_b4;
  logic [15:0] dout1, dout4;
  logic        done1, done4;

  logic [7:0] va [25];
  logic [7:0] vb [25];

  int vectors;
  int miscompares;

  parallel_mac #(.PARALLEL(1), .N_ELEM(25), .DATA_W(8), .ACC_W(16)) dut1 (
    .clk   (clk),
    .rst_b (rst_b),
    .start (start1),
    .din_a (din_a1),
    .din_b (din_b1),
    .dout  (dout1),
    .done  (done1)
  );

  parallel_mac #(.PARALLEL(4), .N_ELEM(25), .DATA_W(8), .ACC_W(16)) dut4 (
    .clk   (clk),
    .rst_b (rst_b),
    .start (start4),
    .din_a (din_a4),
    .din_b (din_b4),
    .dout  (dout4),
    .done  (done4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A = 1..25, B = A+8 except element 10 raised to 32: dot product 8268 = 0x204C.
  task automatic load_ref();
    for (int i = 0; i < 25; i++) begin
      va[i] = 8'(i + 1);
      vb[i] = 8'(i + 9);
    end
    vb[10] = 8'd32;
  endtask

  task automatic load_const(input logic [7:0] v);
    for (int i = 0; i < 25; i++) begin
      va[i] = v;
      vb[i] = v;
    end
  endtask

  task automatic feed1(input bit drop_start);
    start1 = 1'b1;
    for (int k = 0; k < 25; k++) begin
      din_a1 = va[k];
      din_b1 = vb[k];
      tick();
      if (drop_start) start1 = 1'b0;
      if (k == 23) check("p1_not_early", 16'(done1), 16'd0);
    end
  endtask

  task automatic feed4();
    start4 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      for (int j = 0; j < 4; j++) begin
        din_a4[j*8 +: 8] = (k*4 + j < 25) ? va[k*4 + j] : 8'hFF;
        din_b4[j*8 +: 8] = (k*4 + j < 25) ? vb[k*4 + j] : 8'hFF;
      end
      tick();
      if (k == 5) check("p4_not_early", 16'(done4), 16'd0);
    end
  endtask

  initial begin
    clk         = 1'b0;
    rst_b       = 1'b1;
    start1      = 1'b0;
    start4      = 1'b0;
    din_a1      = '0;
    din_b1      = '0;
    din_a4      = '0;
    din_b4      = '0;
    vectors     = 0;
    miscompares = 0;

    tick();
    tick();
    check("rst_dout1", dout1, 16'h0000);
    check("rst_done1", 16'(done1), 16'd0);
    check("rst_dout4", dout4, 16'h0000);
    check("rst_done4", 16'(done4), 16'd0);
    rst_b = 1'b0;
    tick();

    load_ref();
    feed1(1'b0);
    check("ref_dout", dout1, 16'h204C);
    check("ref_done", 16'(done1), 16'd1);
    din_a1 = 8'h33;
    din_b1 = 8'h44;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_done", 16'(done1), 16'd1);
      check("hold_dout", dout1, 16'h204C);
    end

    start1 = 1'b0;
    tick();
    check("drop_done", 16'(done1), 16'd0);
    check("drop_dout", dout1, 16'h204C);

    load_const(8'h01);
    feed1(1'b0);
    check("b2b_dout", dout1, 16'h0019);
    check("b2b_done", 16'(done1), 16'd1);

    start1 = 1'b0;
    tick();
    load_const(8'hFF);
    feed1(1'b0);
    check("ovf_dout", dout1, 16'hCE19);
    check("ovf_done", 16'(done1), 16'd1);

    load_ref();
    feed4();
    check("p4_dout", dout4, 16'h204C);
    check("p4_done", 16'(done4), 16'd1);
    start4 = 1'b0;
    tick();
    check("p4_idle", 16'(done4), 16'd0);

    start1 = 1'b0;
    tick();
    start1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      din_a1 = va[k];
      din_b1 = vb[k];
      tick();
    end
    check("mid_run_dout", dout1, 16'(1*9 + 2*10 + 3*11 + 4*12 + 5*13));
    rst_b  = 1'b1;
    start1 = 1'b0;
    tick();
    check("mid_rst_dout", dout1, 16'h0000);
    check("mid_rst_done", 16'(done1), 16'd0);
    rst_b = 1'b0;
    tick();
    check("post_rst_dout", dout1, 16'h0000);
    check("post_rst_done", 16'(done1), 16'd0);

    load_const(8'h01);
    feed1(1'b1);
    check("nostart_dout", dout1, 16'h0019);
    check("nostart_done", 16'(done1), 16'd1);
    tick();
    check("nostart_idle", 16'(done1), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
